// File: rtl/mem_pkg.sv
// mem_pkg: shared types and defaults for the main-memory controller.
package mem_pkg;
    typedef logic [7:0] byte_t;
    typedef byte_t [0:3] lanes_t;
    typedef enum logic {IDLE, BUSY} state_t;
    localparam int WORD_BYTES = 4;
    localparam int DEF_MEM_BYTES = 65536;
    localparam int DEF_RD_LAT = 4;
    localparam int DEF_WR_LAT = 4;
endpackage

// File: rtl/mem_byte_ram.sv
// mem_byte_ram: byte-array storage with a 4-lane word write port and a registered 4-lane read port.
module mem_byte_ram
    import mem_pkg::*;
#(
    parameter int MEM_BYTES = DEF_MEM_BYTES,
    parameter int AW = $clog2(MEM_BYTES)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic          re,
    input  logic [AW-3:0] widx,
    input  lanes_t        wdata,
    output lanes_t        rdata
);
    byte_t mem [MEM_BYTES];
    // Storage has no reset; only the read register clears.
    always_ff @(posedge clk) begin
        if (we)
            for (int k = 0; k < WORD_BYTES; k++)
                mem[{widx, k[1:0]}] <= wdata[k];
    end
    always_ff @(posedge clk) begin
        if (!reset)
            rdata <= '0;
        else if (re)
            for (int k = 0; k < WORD_BYTES; k++)
                rdata[k] <= mem[{widx, k[1:0]}];
    end
endmodule

// File: rtl/main_mem_ctrl.sv
// main_mem_ctrl: fixed-latency single-word main-memory controller behind the data cache.
// MAIN_MEM_CTRL_STATS_EN adds rd_count/wr_count completion counters.
module main_mem_ctrl
    import mem_pkg::*;
#(
    parameter int MEM_BYTES = DEF_MEM_BYTES,
    parameter int RD_LAT = DEF_RD_LAT,
    parameter int WR_LAT = DEF_WR_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_req,
    input  logic [31:0] address_output,
    input  logic        write_en_out,
    input  lanes_t      mem_data_in,
    output lanes_t      mem_data_out,
    output logic        mem_busy,
    output logic        mem_done
`ifdef MAIN_MEM_CTRL_STATS_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
`endif
);
    localparam int AW = $clog2(MEM_BYTES);
    localparam int MAX_LAT = RD_LAT > WR_LAT ? RD_LAT : WR_LAT;
    localparam int CW = $clog2(MAX_LAT + 1);
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic load, expire, we_l;
    logic [AW-3:0] widx;
    lanes_t data_l;
    assign mem_busy = state == BUSY;
    always_comb begin
        load = state == IDLE && mem_req;
        expire = state == BUSY && cnt == '0;
        state_n = load ? BUSY : expire ? IDLE : state;
        cnt_n = load ? (write_en_out ? CW'(WR_LAT - 1) : CW'(RD_LAT - 1))
              : (state == BUSY && !expire) ? cnt - 1'b1 : cnt;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt <= '0;
            mem_done <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            mem_done <= expire;
        end
    end
    // Request latch: high address bits alias, low two bits word-align.
    always_ff @(posedge clk) begin
        if (load) begin
            widx <= address_output[AW-1:2];
            we_l <= write_en_out;
            data_l <= mem_data_in;
        end
    end
`ifdef MAIN_MEM_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else if (expire) begin
            rd_count <= rd_count + {31'd0, !we_l};
            wr_count <= wr_count + {31'd0, we_l};
        end
    end
`endif
    mem_byte_ram #(.MEM_BYTES(MEM_BYTES)) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (expire && we_l && reset),
        .re    (expire && !we_l),
        .widx  (widx),
        .wdata (data_l),
        .rdata (mem_data_out)
    );
endmodule

// File: tb/tb_main_mem_ctrl.sv
// tb_main_mem_ctrl: directed self-checking bench for main_mem_ctrl (default and short-latency builds).
module tb_main_mem_ctrl;
    import mem_pkg::*;
    logic clk = 1'b0;
    logic a_reset, a_req, a_we, a_busy, a_done;
    logic [31:0] a_addr;
    lanes_t a_din, a_dout;
    logic b_reset, b_req, b_we, b_busy, b_done;
    logic [31:0] b_addr;
    lanes_t b_din, b_dout;
    int checks = 0;
    int errors = 0;
`ifdef MAIN_MEM_CTRL_STATS_EN
    logic [31:0] a_rdc, a_wrc, b_rdc, b_wrc;
`endif
    main_mem_ctrl u_a (
        .clk(clk), .reset(a_reset), .mem_req(a_req), .address_output(a_addr),
        .write_en_out(a_we), .mem_data_in(a_din), .mem_data_out(a_dout),
        .mem_busy(a_busy), .mem_done(a_done)
`ifdef MAIN_MEM_CTRL_STATS_EN
        , .rd_count(a_rdc), .wr_count(a_wrc)
`endif
    );
    main_mem_ctrl #(.MEM_BYTES(65536), .RD_LAT(1), .WR_LAT(2)) u_b (
        .clk(clk), .reset(b_reset), .mem_req(b_req), .address_output(b_addr),
        .write_en_out(b_we), .mem_data_in(b_din), .mem_data_out(b_dout),
        .mem_busy(b_busy), .mem_done(b_done)
`ifdef MAIN_MEM_CTRL_STATS_EN
        , .rd_count(b_rdc), .wr_count(b_wrc)
`endif
    );
    initial forever #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    task automatic a_issue(input logic [31:0] addr, input logic we, input logic [31:0] d);
        a_addr = addr;
        a_we = we;
        a_din = d;
        a_req = 1'b1;
        tick();
        a_req = 1'b0;
    endtask
    task automatic b_issue(input logic [31:0] addr, input logic we, input logic [31:0] d);
        b_addr = addr;
        b_we = we;
        b_din = d;
        b_req = 1'b1;
        tick();
        b_req = 1'b0;
    endtask
    // Edges after the sampling edge until done rises; 30 means it never came.
    task automatic wait_done(input bit use_b, input string tag, input int lat);
        int n = 0;
        while (n < 30) begin
            tick();
            n++;
            if (use_b ? b_done : a_done) break;
        end
        chk(tag, n, lat);
    endtask
    task automatic count_done(input string tag, input int cycles, input int exp);
        int n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (a_done) n++;
        end
        chk(tag, n, exp);
    endtask
    initial begin
        a_reset = 1'b0; a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_din = '0;
        b_reset = 1'b0; b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_din = '0;
        tick();
        tick();
        chk("rst_busy", {31'd0, a_busy}, 32'd0);
        chk("rst_done", {31'd0, a_done}, 32'd0);
        chk("rst_data", a_dout, 32'h0000_0000);
        a_reset = 1'b1;
        b_reset = 1'b1;
        tick();
        a_issue(32'h0000_0100, 1'b1, 32'hDEAD_BEEF);
        chk("wr_busy", {31'd0, a_busy}, 32'd1);
        chk("wr_nodone", {31'd0, a_done}, 32'd0);
        wait_done(0, "wr_lat", 4);
        chk("wr_done_busy", {31'd0, a_busy}, 32'd0);
        chk("wr_keeps_dout", a_dout, 32'h0000_0000);
        a_issue(32'h0000_0100, 1'b0, 32'h0);
        chk("done_one_cycle", {31'd0, a_done}, 32'd0);
        wait_done(0, "rd_lat", 4);
        chk("rd_data", a_dout, 32'hDEAD_BEEF);
        a_issue(32'h0000_0200, 1'b1, 32'h5566_7788);
        wait_done(0, "pre200_lat", 4);
        chk("rd_data_held", a_dout, 32'hDEAD_BEEF);
        a_issue(32'h0000_0000, 1'b0, 32'h0);
        tick();
        a_issue(32'h0000_0200, 1'b1, 32'h0102_0304);
        wait_done(0, "busy_rej_lat", 2);
        count_done("busy_rej_extra", 12, 0);
        a_issue(32'h0000_0200, 1'b0, 32'h0);
        wait_done(0, "rd200_lat", 4);
        chk("rd200_data", a_dout, 32'h5566_7788);
        a_issue(32'h0000_0300, 1'b1, 32'hA0B0_C0D0);
        wait_done(0, "pre300_lat", 4);
        a_issue(32'h0000_0300, 1'b1, 32'h1122_3344);
        tick();
        a_reset = 1'b0;
        tick();
        a_reset = 1'b1;
        chk("abort_busy", {31'd0, a_busy}, 32'd0);
        chk("abort_dout", a_dout, 32'h0000_0000);
        count_done("abort_nodone", 8, 0);
        a_issue(32'h0000_0300, 1'b0, 32'h0);
        wait_done(0, "rd300_lat", 4);
        chk("rd300_data", a_dout, 32'hA0B0_C0D0);
        a_issue(32'h0001_0103, 1'b1, 32'hCAFE_BABE);
        a_din = 32'hFFFF_FFFF;
        wait_done(0, "alias_wr_lat", 4);
        a_issue(32'h0000_0100, 1'b0, 32'h0);
        wait_done(0, "alias_rd_lat", 4);
        chk("alias_data", a_dout, 32'hCAFE_BABE);
`ifdef MAIN_MEM_CTRL_STATS_EN
        chk("a_rd_count", a_rdc, 32'd2);
        chk("a_wr_count", a_wrc, 32'd1);
`endif
        b_issue(32'h0000_0040, 1'b1, 32'h0102_0304);
        wait_done(1, "b_wr_lat", 2);
        b_issue(32'h0000_0040, 1'b0, 32'h0);
        wait_done(1, "b_rd_lat", 1);
        chk("b_rd_data", b_dout, 32'h0102_0304);
        chk("b_busy_at_done", {31'd0, b_busy}, 32'd0);
`ifdef MAIN_MEM_CTRL_STATS_EN
        chk("b_rd_count", b_rdc, 32'd1);
        chk("b_wr_count", b_wrc, 32'd1);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
